// File: rtl/bk_sector_ctrl.sv
// rtl/bk_sector_ctrl.sv - backup RAM <-> SD sector transfer sequencer; optional autoload after cart download under `BK_AUTOLOAD_EN
module bk_sector_ctrl #(
  parameter int SECTORS = 16,
  parameter int LBA_W   = 4
) (
  input  logic        clk_sys,
  input  logic        reset,
  input  logic        cart_download,
  input  logic        img_mounted,
  input  logic        img_readonly,
  input  logic        img_size_nz,
  input  logic        load_req,
  input  logic        save_req,
  input  logic        format_req,
  input  logic        autosave,
  input  logic        osd_status,
  input  logic        bram_wr,
  input  logic        sd_ack,
  output logic [31:0] sd_lba,
  output logic        sd_rd,
  output logic        sd_wr,
  output logic        bk_ena,
  output logic        bk_busy,
  output logic        bk_loading,
  output logic        bk_pending,
  output logic        def_sel,
  output logic [1:0]  def_addr,
  output logic [15:0] def_data,
  output logic        def_we
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_REQ,
    ST_XFER,
    ST_FORMAT
  } state_t;

  localparam logic [LBA_W-1:0] LBA_LAST = LBA_W'(SECTORS - 1);

  state_t           state;
  logic [LBA_W-1:0] lba_q;

  logic dl_old;
  logic load_old;
  logic save_old;
  logic fmt_old;
  logic auto_old;
  logic ack_old;
  logic fmt_latched;

  logic auto_term;
  logic dl_rise;
  logic dl_fall;
  logic load_rise;
  logic save_rise;
  logic fmt_rise;
  logic auto_rise;
  logic ack_rise;
  logic ack_fall;
  logic autoload_trig;
  logic load_trig;
  logic save_trig;
  logic start_xfer;
  logic fmt_go;
  logic ena_set;

  // Header words that make a freshly formatted backup RAM look valid to the core.
  function automatic logic [15:0] def_word(input logic [1:0] idx);
    case (idx)
      2'd0:    def_word = 16'h5548;
      2'd1:    def_word = 16'h4D42;
      2'd2:    def_word = 16'h8800;
      default: def_word = 16'h8010;
    endcase
  endfunction

  assign auto_term = bk_pending && osd_status && autosave;

  assign dl_rise   = cart_download && !dl_old;
  assign dl_fall   = !cart_download && dl_old;
  assign load_rise = load_req && !load_old;
  assign save_rise = save_req && !save_old;
  assign fmt_rise  = format_req && !fmt_old;
  assign auto_rise = auto_term && !auto_old;
  assign ack_rise  = sd_ack && !ack_old;
  assign ack_fall  = !sd_ack && ack_old;

`ifdef BK_AUTOLOAD_EN
  assign autoload_trig = dl_fall && img_size_nz && bk_ena;
`else
  assign autoload_trig = 1'b0;
  logic unused_autoload;
  assign unused_autoload = dl_fall & img_size_nz;
`endif

  assign load_trig  = load_rise || autoload_trig;
  assign save_trig  = save_rise || auto_rise;
  assign start_xfer = (state == ST_IDLE) && bk_ena && (load_trig || save_trig);
  assign fmt_go     = (state == ST_IDLE) && !start_xfer && (fmt_rise || fmt_latched);
  assign ena_set    = cart_download && img_mounted && !img_readonly;

  assign sd_lba = {{(32 - LBA_W){1'b0}}, lba_q};

  // Edge-detector history; also loaded during reset so no edge is seen on release.
  always_ff @(posedge clk_sys) begin
    dl_old   <= cart_download;
    load_old <= load_req;
    save_old <= save_req;
    fmt_old  <= format_req;
    auto_old <= auto_term;
    ack_old  <= sd_ack;
  end

  // Save image attach flag: a fresh download detaches, a writable mount during download attaches.
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      bk_ena <= 1'b0;
    end else if (ena_set) begin
      bk_ena <= 1'b1;
    end else if (dl_rise) begin
      bk_ena <= 1'b0;
    end
  end

  // Dirty flag: core writes while the OSD is closed mark RAM newer than the image.
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      bk_pending <= 1'b0;
    end else if (bk_ena && !osd_status && bram_wr) begin
      bk_pending <= 1'b1;
    end else if (bk_busy) begin
      bk_pending <= 1'b0;
    end
  end

  // Holds a format request that could not run immediately until the next free IDLE cycle.
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      fmt_latched <= 1'b0;
    end else if (fmt_go) begin
      fmt_latched <= 1'b0;
    end else if (fmt_rise) begin
      fmt_latched <= 1'b1;
    end
  end

  // Transfer / format sequencer with registered handshake and default-write outputs.
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      state      <= ST_IDLE;
      lba_q      <= '0;
      sd_rd      <= 1'b0;
      sd_wr      <= 1'b0;
      bk_busy    <= 1'b0;
      bk_loading <= 1'b0;
      def_sel    <= 1'b0;
      def_addr   <= 2'd0;
      def_data   <= 16'h0000;
      def_we     <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start_xfer) begin
            state      <= ST_REQ;
            lba_q      <= '0;
            bk_busy    <= 1'b1;
            bk_loading <= load_trig;
            sd_rd      <= load_trig;
            sd_wr      <= !load_trig;
          end else if (fmt_go) begin
            state    <= ST_FORMAT;
            def_sel  <= 1'b1;
            def_we   <= 1'b1;
            def_addr <= 2'd0;
            def_data <= def_word(2'd0);
          end
        end

        ST_REQ: begin
          if (ack_rise) begin
            sd_rd <= 1'b0;
            sd_wr <= 1'b0;
            state <= ST_XFER;
          end
        end

        ST_XFER: begin
          if (ack_fall) begin
            if (lba_q == LBA_LAST) begin
              state      <= ST_IDLE;
              bk_busy    <= 1'b0;
              bk_loading <= 1'b0;
            end else begin
              lba_q <= lba_q + 1'b1;
              sd_rd <= bk_loading;
              sd_wr <= !bk_loading;
              state <= ST_REQ;
            end
          end
        end

        ST_FORMAT: begin
          if (def_addr == 2'd3) begin
            state    <= ST_IDLE;
            def_sel  <= 1'b0;
            def_we   <= 1'b0;
            def_addr <= 2'd0;
            def_data <= 16'h0000;
          end else begin
            def_addr <= def_addr + 2'd1;
            def_data <= def_word(def_addr + 2'd1);
          end
        end

        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
